// File: rtl/time_display_driver.sv
// Converts the stopwatch time to BCD with a sequential double-dabble engine and
// scans the committed BCD value onto a 6-digit multiplexed 7-segment display.
module time_display_driver #(
  parameter int SCAN_DIV       = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  seconds,
  input  logic [7:0]  minutes,
  input  logic [7:0]  hours,
  output logic [23:0] bcd_time,
  output logic        bcd_valid,
  output logic        overflow,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [5:0]  digit_sel
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  function automatic logic [7:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // One adjust-then-shift step on {bcd_tens, bcd_ones, binary}.
  function automatic logic [15:0] dabble_step(input logic [15:0] v);
    logic [15:0] t;
    t         = v;
    t[11:8]   = (t[11:8]  >= 4'd5) ? (t[11:8]  + 4'd3) : t[11:8];
    t[15:12]  = (t[15:12] >= 4'd5) ? (t[15:12] + 4'd3) : t[15:12];
    return {t[14:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  state_t            state_r, state_s;
  logic              stale_r, stale_s;
  logic [23:0]       cap_r, cap_s;
  logic [23:0]       bin_r, bin_s;
  logic [23:0]       acc_r, acc_s;
  logic [2:0]        sat_r, sat_s;
  logic [2:0]        iter_r, iter_s;
  logic [23:0]       bcd_time_r, bcd_time_s;
  logic              bcd_valid_r, bcd_valid_s;
  logic              overflow_r, overflow_s;
  logic              busy_r, busy_s;
  logic [DIV_W-1:0]  div_r, div_s;
  logic [2:0]        idx_r, idx_s;
  logic [5:0]        digit_sel_r, digit_sel_s;
  logic [6:0]        seg_r, seg_s;
  logic [15:0]       step_s;
  logic [3:0]        nibble_s;

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_s     = state_r;
    stale_s     = stale_r;
    cap_s       = cap_r;
    bin_s       = bin_r;
    acc_s       = acc_r;
    sat_s       = sat_r;
    iter_s      = iter_r;
    bcd_time_s  = bcd_time_r;
    bcd_valid_s = bcd_valid_r;
    overflow_s  = overflow_r;
    step_s      = 16'h0000;
    case (state_r)
      IDLE: begin
        if (stale_r || ({hours, minutes, seconds} != cap_r)) begin
          cap_s   = {hours, minutes, seconds};
          stale_s = 1'b0;
          bin_s   = {sat99(hours), sat99(minutes), sat99(seconds)};
          sat_s   = {(hours > 8'd99), (minutes > 8'd99), (seconds > 8'd99)};
          acc_s   = 24'h000000;
          iter_s  = 3'd0;
          state_s = CONVERT;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        for (int f = 0; f < 3; f++) begin
          step_s            = dabble_step({acc_r[f*8 +: 8], bin_r[f*8 +: 8]});
          acc_s[f*8 +: 8]   = step_s[15:8];
          bin_s[f*8 +: 8]   = step_s[7:0];
        end
        iter_s = iter_r + 3'd1;
        if (iter_r == 3'd7) begin
          state_s = COMMIT;
        end else begin
          state_s = CONVERT;
        end
      end
      COMMIT: begin
        bcd_time_s  = acc_r;
        bcd_valid_s = 1'b1;
        overflow_s  = |sat_r;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Scan divider, digit index and the segment value for the next cycle, so that
  // seg and digit_sel move together on the same edge.
  always_comb begin
    div_s = div_r;
    idx_s = idx_r;
    if (div_r == DIV_LAST) begin
      div_s = '0;
      idx_s = (idx_r == 3'd5) ? 3'd0 : (idx_r + 3'd1);
    end else begin
      div_s = div_r + DIV_W'(1);
      idx_s = idx_r;
    end
    digit_sel_s = 6'b000001 << idx_s;
    nibble_s    = bcd_time_s[{idx_s, 2'b00} +: 4];
    if (bcd_valid_s) begin
      seg_s = SEG_ACTIVE_LOW ? ~seg_pattern(nibble_s) : seg_pattern(nibble_s);
    end else begin
      seg_s = SEG_OFF;
    end
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      stale_r     <= 1'b1;
      cap_r       <= 24'h000000;
      bin_r       <= 24'h000000;
      acc_r       <= 24'h000000;
      sat_r       <= 3'b000;
      iter_r      <= 3'd0;
      bcd_time_r  <= 24'h000000;
      bcd_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      div_r       <= '0;
      idx_r       <= 3'd0;
      digit_sel_r <= 6'b000001;
      seg_r       <= SEG_OFF;
    end else begin
      state_r     <= state_s;
      stale_r     <= stale_s;
      cap_r       <= cap_s;
      bin_r       <= bin_s;
      acc_r       <= acc_s;
      sat_r       <= sat_s;
      iter_r      <= iter_s;
      bcd_time_r  <= bcd_time_s;
      bcd_valid_r <= bcd_valid_s;
      overflow_r  <= overflow_s;
      busy_r      <= busy_s;
      div_r       <= div_s;
      idx_r       <= idx_s;
      digit_sel_r <= digit_sel_s;
      seg_r       <= seg_s;
    end
  end

  assign bcd_time  = bcd_time_r;
  assign bcd_valid = bcd_valid_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;
  assign seg       = seg_r;
  assign digit_sel = digit_sel_r;

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
Consumer of the stopwatch time outputs (seconds, minutes, hours, each 8-bit binary). Snapshots the time triple and converts each field to two BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives a 6-digit time-multiplexed 7-segment display from the last committed BCD value, so a partial conversion is never shown. Sits between the time counter and the FPGA display pins.

Parameters:
SCAN_DIV, 250, clock ticks each digit stays enabled before the scan advances (must be >= 2).
SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (0 lights a segment); 0 = active-high.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
seconds  in  8  binary seconds from the time counter
minutes  in  8  binary minutes from the time counter
hours  in  8  binary hours from the time counter
bcd_time  out  24  committed BCD, {H1,H0,M1,M0,S1,S0}, 4 bits per digit, H1 is the MSB nibble
bcd_valid  out  1  high once at least one conversion has committed since reset
overflow  out  1  last committed snapshot had at least one field above 99
busy  out  1  high in CONVERT and COMMIT
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a, polarity set by SEG_ACTIVE_LOW
digit_sel  out  6  one-hot, active-high digit enable; bit0 = S0 (rightmost), bit5 = H1

Behaviour:
- All state changes on posedge clock. reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - state = IDLE; bcd_time = 0; bcd_valid = 0; overflow = 0; busy = 0.
  - Scan divider = 0; digit index = 0; digit_sel = 6'b000001.
  - seg = all segments off (7'h7F when active-low, 7'h00 when active-high).
  - The snapshot is marked stale, so the first IDLE edge after reset always captures.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE, capture condition: the snapshot is stale, or {hours,minutes,seconds} differs from the last captured triple.
  - On a capture edge, store the raw triple for comparison.
  - Load each field into the shift register, saturated to 99 if it is above 99, and record per-field saturation.
  - Clear the BCD accumulators, set iter = 0, go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT: one double-dabble step per edge, on all three fields in parallel.
  - In each field, any BCD nibble >= 5 gets +3.
  - Then shift the accumulator and binary register left one bit.
  - After the 8th step (iter = 7), go to COMMIT.
- COMMIT, one edge:
  - bcd_time <= accumulators; bcd_valid <= 1.
  - overflow <= OR of the saturation flags; go to IDLE.
- Latency: bcd_time updates exactly 9 edges after the capture edge (8 CONVERT plus 1 COMMIT). Back-to-back minimum period is 10 cycles.
- Input changes during CONVERT or COMMIT are ignored for the current pass. The next IDLE edge compares against the captured triple and recaptures.
- Fields 60..99 in seconds or minutes are converted as-is. Range checking against the time format is not this block's job.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the digit index advances 0→1→…→5→0.
  - digit_sel = 1 << index.
  - The scan is independent of the FSM and runs from reset.
- Segment decode:
  - Combinational from bcd_time nibble[index]; no pipeline, so seg and digit_sel change on the same edge.
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles A–F show blank.
  - Active-low is the bitwise inverse.
  - While bcd_valid = 0, seg = off.
- Reset during CONVERT or COMMIT:
  - Aborts the pass; no commit occurs.
  - All outputs return to their reset values on that edge.

Test Plan:
1. Reset 2 cycles, inputs 0/0/0 → capture on first edge after reset, bcd_time = 24'h000000 and bcd_valid = 1 nine edges later, busy high for those 9 cycles.
2. hours=12, minutes=34, seconds=56 → bcd_time = 24'h123456, overflow = 0. With SEG_ACTIVE_LOW=1 and digit 0 selected, seg = 7'h02 (inverse of 7D).
3. hours=150 → bcd_time[23:16] = 8'h99, overflow = 1. Then hours=7 → 8'h07, overflow = 0 after the next commit.
4. SCAN_DIV=4 → digit_sel steps 000001→000010 after 4 cycles, reaches 100000 at cycle 20, returns to 000001 at cycle 24. Each step shows the matching digit of 24'h123456.
5. Start conversion of s=10, change s to 11 on the 3rd CONVERT edge → first commit 24'h000010. Recapture on the following IDLE edge, second commit 24'h000011, 10 edges after the first commit.
6. Assert reset on the 5th CONVERT edge → state IDLE, bcd_valid = 0, bcd_time = 0, seg = 7'h7F, digit_sel = 000001. Fresh capture after reset drops.
